ball_physics: RTL and testbench

Frame-rate ball and score engine for the pong game. It sits directly upstream of the display top, driving its `x_ball`, `y_ball`, `player1_score` and `player2_score` inputs. It advances the ball once per `timing_tick`, handles wall bounces, paddle hits and misses, and counts points up to a win. Paddle positions come from the player controllers and use the same top-left pixel coordinates the drawing stage uses.

---
 rtl/ball_physics.sv | 134 +++++++++++++
 tb/tb_ball_physics.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ball_physics.sv
// ball_physics: per-frame ball motion, paddle/wall bounces, scoring and match FSM for pong.
module ball_physics #(
  parameter int H_RES       = 1024,
  parameter int V_RES       = 768,
  parameter int BALL_SIZE   = 16,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 100,
  parameter int PAD_LEFT_X  = 20,
  parameter int PAD_RIGHT_X = 994,
  parameter int SPEED       = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [9:0]  y_ball,
  output logic [3:0]  player1_score,
  output logic [3:0]  player2_score,
  output logic        game_over,
  output logic        winner
);
  localparam logic [10:0] XC = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] YC = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] PH = 11'(PAD_H);
  localparam logic [10:0] LX = 11'(PAD_LEFT_X + PAD_W);
  localparam logic [10:0] RX = 11'(PAD_RIGHT_X);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  localparam logic [3:0]  WS = 4'(WIN_SCORE);
  localparam int          CW = $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] SD = CW'(SERVE_DELAY);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  state_t state, state_nx;
  logic [10:0] x_nx, yw, yl, yr, x_mv, y_mv;
  logic [9:0]  y_nx;
  logic [3:0]  p1_nx, p2_nx, p1_inc, p2_inc;
  logic        go_nx, winner_nx, dir_x, dir_y, dx_nx, dy_nx, dx_mv, dy_mv;
  logic [CW-1:0] cnt, cnt_nx;
  logic        ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r, top, bot, win;
  assign yw = {1'b0, y_ball};
  assign yl = {1'b0, y_pad_left};
  assign yr = {1'b0, y_pad_right};
  assign ovl_l = (yw + BS > yl) && (yw < yl + PH);
  assign ovl_r = (yw + BS > yr) && (yw < yr + PH);
  // x_ball >= LX guards the subtraction, so the left hit test never wraps
  assign hit_l = !dir_x && x_ball >= LX && x_ball - SP <= LX && ovl_l;
  assign hit_r = dir_x && x_ball + BS <= RX && x_ball + BS + SP >= RX && ovl_r;
  assign miss_l = !dir_x && x_ball <= SP;
  assign miss_r = dir_x && x_ball + BS + SP >= HR;
  assign top = !dir_y && yw <= SP;
  assign bot = dir_y && yw + BS + SP >= VR;
  assign y_mv = top ? 11'd0 : bot ? VR - BS : dir_y ? yw + SP : yw - SP;
  assign dy_mv = top ? 1'b1 : bot ? 1'b0 : dir_y;
  assign x_mv = hit_l ? LX : hit_r ? RX - BS : dir_x ? x_ball + SP : x_ball - SP;
  assign dx_mv = hit_l ? 1'b1 : hit_r ? 1'b0 : dir_x;
  assign p1_inc = player1_score + 4'd1;
  assign p2_inc = player2_score + 4'd1;
  assign win = miss_r ? p1_inc == WS : p2_inc == WS;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x_ball <= XC;
      y_ball <= YC[9:0];
      player1_score <= '0;
      player2_score <= '0;
      game_over <= 1'b0;
      winner <= 1'b0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      cnt <= '0;
    end else begin
      state <= state_nx;
      x_ball <= x_nx;
      y_ball <= y_nx;
      player1_score <= p1_nx;
      player2_score <= p2_nx;
      game_over <= go_nx;
      winner <= winner_nx;
      dir_x <= dx_nx;
      dir_y <= dy_nx;
      cnt <= cnt_nx;
    end
  end
  always_comb begin
    state_nx = state;
    x_nx = x_ball;
    y_nx = y_ball;
    p1_nx = player1_score;
    p2_nx = player2_score;
    go_nx = game_over;
    winner_nx = winner;
    dx_nx = dir_x;
    dy_nx = dir_y;
    cnt_nx = cnt;
    if ((state == IDLE || state == OVER) && start) begin
      state_nx = SERVE;
      x_nx = XC;
      y_nx = YC[9:0];
      p1_nx = '0;
      p2_nx = '0;
      go_nx = 1'b0;
      dx_nx = 1'b1;
      dy_nx = 1'b1;
      cnt_nx = SD;
    end else if (state == SERVE && timing_tick) begin
      cnt_nx = cnt <= CW'(1) ? '0 : cnt - CW'(1);
      state_nx = cnt <= CW'(1) ? PLAY : SERVE;
    end else if (state == PLAY && timing_tick) begin
      if (miss_l || miss_r) begin
        x_nx = XC;
        y_nx = YC[9:0];
        dx_nx = miss_r;
        p1_nx = miss_r ? p1_inc : player1_score;
        p2_nx = miss_l ? p2_inc : player2_score;
        state_nx = win ? OVER : SERVE;
        go_nx = win;
        winner_nx = win ? miss_l : winner;
        cnt_nx = SD;
      end else begin
        x_nx = x_mv;
        y_nx = y_mv[9:0];
        dx_nx = dx_mv;
        dy_nx = dy_mv;
      end
    end
  end
endmodule

// File: tb/tb_ball_physics.sv
// tb_ball_physics: directed rallies with hand-computed ball positions and scores.
module tb_ball_physics;
  logic clk = 1'b0, rst = 1'b1, timing_tick = 1'b0, start = 1'b0;
  logic [9:0] y_pad_left = 10'd250, y_pad_right = 10'd600;
  logic [10:0] x_ball;
  logic [9:0] y_ball;
  logic [3:0] player1_score, player2_score;
  logic game_over, winner;
  int total = 0, bad = 0;
  ball_physics dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .start(start),
    .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
    .x_ball(x_ball), .y_ball(y_ball),
    .player1_score(player1_score), .player2_score(player2_score),
    .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(x_ball), x);
    chk({tag, "_y"}, 32'(y_ball), y);
  endtask
  task automatic score(input string tag, input int p1, input int p2, input int go);
    chk({tag, "_p1"}, 32'(player1_score), p1);
    chk({tag, "_p2"}, 32'(player2_score), p2);
    chk({tag, "_go"}, 32'(game_over), go);
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      timing_tick = 1'b1;
      @(negedge clk);
      timing_tick = 1'b0;
    end
  endtask
  initial begin
    #2 rst = 1'b0;
    #10;
    pos("rst", 504, 376);
    score("rst", 0, 0, 0);
    chk("rst_winner", 32'(winner), 0);
    @(negedge clk);
    rst = 1'b1;
    tick_n(3);
    pos("idle_ticks", 504, 376);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tick_n(60);
    pos("serve_end", 504, 376);
    tick_n(1);
    pos("t1", 508, 380);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tick_n(92);
    pos("t93", 876, 748);
    tick_n(1);
    pos("bottom_bounce", 880, 752);
    tick_n(1);
    pos("after_bottom", 884, 748);
    tick_n(24);
    pos("right_hit", 978, 652);
    tick_n(1);
    pos("after_right_hit", 974, 648);
    tick_n(161);
    pos("t281", 330, 4);
    tick_n(1);
    pos("top_bounce", 326, 0);
    tick_n(1);
    pos("after_top", 322, 4);
    tick_n(73);
    pos("left_hit", 30, 296);
    tick_n(1);
    pos("after_left_hit", 34, 300);
    score("rally", 0, 0, 0);
    y_pad_left = 10'd900;
    y_pad_right = 10'd900;
    tick_n(243);
    pos("past_right_pad", 1006, 232);
    tick_n(1);
    pos("p1_point", 504, 376);
    score("p1_point", 1, 0, 0);
    tick_n(186);
    score("p1_second", 2, 0, 0);
    tick_n(186 * 7);
    score("p1_win", 9, 0, 1);
    chk("p1_win_winner", 32'(winner), 0);
    pos("over", 504, 376);
    tick_n(5);
    score("over_ticks", 9, 0, 1);
    pos("over_ticks", 504, 376);
    @(negedge clk);
    start = 1'b1;
    timing_tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timing_tick = 1'b0;
    score("restart", 0, 0, 0);
    y_pad_right = 10'd600;
    tick_n(60);
    pos("restart_serve", 504, 376);
    tick_n(1);
    pos("restart_t1", 508, 380);
    tick_n(118);
    pos("restart_right_hit", 978, 652);
    tick_n(244);
    pos("past_left_pad", 2, 324);
    score("past_left_pad", 0, 0, 0);
    tick_n(1);
    pos("p2_point", 504, 376);
    score("p2_point", 0, 1, 0);
    tick_n(60);
    pos("p2_serve", 504, 376);
    tick_n(1);
    pos("serve_left", 500, 380);
    tick_n(10);
    pos("pre_reset", 460, 420);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    pos("async_rst", 504, 376);
    score("async_rst", 0, 0, 0);
    chk("async_rst_winner", 32'(winner), 0);
    @(negedge clk) rst = 1'b1;
    tick_n(3);
    pos("post_rst_idle", 504, 376);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
